mux5_rr_arbiter: RTL
====================

Name: mux5_rr_arbiter

Overview:
Round-robin arbiter and sequencer for the parameterized 5-to-1 select mux (inputs u, v, w, x, y; 3-bit select).
- Five requesters share the mux output path.
- The block grants one requester at a time, drives the mux select and a one-hot grant, and holds each grant for a bounded burst under a valid/ready handshake with the downstream consumer.
- Sits beside the mux instance; the mux datapath itself stays purely combinational.

Parameters:
DATA_WIDTH, 8, width of the mux data path the arbiter sequences; not used internally, passed through for integration checks.
MAX_HOLD, 4, maximum beats per grant before forced release; legal range 1..15.

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req  input  5  request per source; bit0=u, bit1=v, bit2=w, bit3=x, bit4=y
last  input  5  per-source end-of-burst marker, sampled only on an accepted beat of the granted source
out_ready  input  1  downstream accepts the current mux output
sel  output  3  mux select; 000=u, 001=v, 010=w, 011=x, 100=y
grant  output  5  one-hot grant, all zero when idle
out_valid  output  1  mux output is valid this cycle
busy  output  1  a grant is active

Behaviour:
Clock and reset:
- One clock, clk.
- Reset is asynchronous and active-low on rst_n.

Reset values:
- sel=000, grant=00000, busy=0, out_valid=0.
- State=IDLE, beat_cnt=0.
- Priority pointer=4, so source u wins first.

States:
- IDLE: no grant.
- GRANT: one source owns the mux.

IDLE transitions:
- If req is non-zero, the next clock enters GRANT.
- Winner is the first set req bit scanning upward (mod 5) from pointer+1.
- sel, grant, and pointer are registered to the winner; beat_cnt is cleared.

Handshake and outputs:
- out_valid = busy & req[g], where g is the current winner. Combinational from req; all other outputs are registered.
- beat = out_valid & out_ready.
- On each beat, beat_cnt increments.

Release conditions in GRANT (any one):
- beat with last[g]=1.
- beat with beat_cnt==MAX_HOLD-1.
- req[g]=0 with no beat (requester withdrew).

On release:
- If any other req bit is set, go directly to GRANT with the new round-robin winner on the next clock (no idle bubble). The releasing source has lowest priority.
- If no other req bit is set, the releasing source may win again only if req[g] is still set. Otherwise go to IDLE, with grant=0, busy=0, and sel holding its last value.

Hold and backpressure:
- No release while out_valid=1 and out_ready=0; the grant holds indefinitely under backpressure.
- Changes to non-granted req bits never affect sel mid-grant.

Encoding and widths:
- sel never takes 101..111.
- beat_cnt is 4 bits and saturates at MAX_HOLD-1; it never wraps.
- Pointer arithmetic is mod 5: after 4 comes 0.

Simultaneous events:
- A release and a new request in the same cycle are evaluated together; the new request is eligible in that arbitration.
- An rst_n assertion mid-burst clears everything immediately (asynchronously), regardless of out_ready. No beat completes in that cycle.

Latency:
- From req rising in IDLE to out_valid: 1 clock.
- From release to the next winner's out_valid: 1 clock.

Decomposition:
Shared package (mux5_pkg):
- NUM_SRC=5.
- Select encodings SEL_U..SEL_Y.
- State encoding ST_IDLE, ST_GRANT.
- Function rr_next(pointer, req) returning a 3-bit index.

Sub-module:
- One natural sub-module, rr_pick5: combinational rotating priority encoder (pointer, req -> winner index, any_req).
- The top holds the FSM, beat counter, and output registers.

Test Plan:
1. Reset, then req=00001, last=00001, out_ready=1 -> next clock sel=000, grant=00001, out_valid=1. The beat with last releases; the following cycle grant=00000, busy=0.
2. req=11111 held, last=0, out_ready=1, MAX_HOLD=4 -> grants rotate u,v,w,x,y,u with 4 beats each and no idle cycles. sel sequence: 000,001,010,011,100,000.
3. Grant to w (sel=010) with out_ready=0 for 10 cycles while req=11111 -> sel/grant unchanged and beat_cnt stays 0. After out_ready=1, exactly 4 beats, then grant moves to x.
4. Grant to v; v drops req mid-burst with req[4]=1 -> next clock sel=100, grant=10000. Burst continues for y.
5. Only x requesting, last=0, MAX_HOLD=4 -> after 4 beats x is re-granted with beat_cnt cleared.
6. rst_n pulsed low mid-burst on y -> outputs go to reset values asynchronously. After release with req=11111, the first winner is u (sel=000).

Source files
------------

// File: rtl/mux5_pkg.sv
// Shared definitions for the 5-source round-robin arbiter.
// Contents:
//   NUM_SRC        number of requesters (u, v, w, x, y)
//   SEL_U..SEL_Y   mux select encodings
//   state_e        arbiter FSM states
//   rr_next()      round-robin winner: first set req bit scanning up (mod 5) from ptr+1
package mux5_pkg;

    localparam int unsigned NUM_SRC = 5;

    localparam logic [2:0] SEL_U = 3'd0;
    localparam logic [2:0] SEL_V = 3'd1;
    localparam logic [2:0] SEL_W = 3'd2;
    localparam logic [2:0] SEL_X = 3'd3;
    localparam logic [2:0] SEL_Y = 3'd4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // The source at ptr is examined last, so the previous owner has the lowest
    // priority. Returns ptr unchanged when req is all zero.
    function automatic logic [2:0] rr_next(input logic [2:0] ptr, input logic [4:0] req);
        logic [2:0] idx;
        logic [2:0] result;
        logic       found;
        idx    = ptr;
        result = ptr;
        found  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            idx = (idx >= SEL_Y) ? SEL_U : idx + 3'd1;
            if (!found && req[idx]) begin
                result = idx;
                found  = 1'b1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick5.sv
// Combinational rotating priority encoder for five requesters.
// Ports:
//   ptr_i      index of the previous winner (lowest priority this round)
//   req_i      request vector, bit0=u .. bit4=y
//   winner_o   index of the next winner (valid when any_req_o is set)
//   any_req_o  at least one request is pending
module rr_pick5
    import mux5_pkg::*;
(
    input  logic [2:0] ptr_i,
    input  logic [4:0] req_i,
    output logic [2:0] winner_o,
    output logic       any_req_o
);

    always_comb begin
        winner_o  = rr_next(ptr_i, req_i);
        any_req_o = |req_i;
    end

endmodule

// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter/sequencer for a 5-to-1 select mux. Grants one source at a
// time, drives the mux select and a one-hot grant, and bounds each grant to
// MAX_HOLD accepted beats under a valid/ready handshake.
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req        per-source request, bit0=u .. bit4=y
//   last       per-source end-of-burst marker, used only on an accepted beat of the owner
//   out_ready  downstream accepts the current mux output
//   sel        mux select (registered), 0=u .. 4=y
//   grant      one-hot grant (registered), zero when idle
//   out_valid  busy & req of the owner (combinational from req)
//   busy       a grant is active (registered)
module mux5_rr_arbiter
    import mux5_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_HOLD   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] req,
    input  logic [4:0] last,
    input  logic       out_ready,
    output logic [2:0] sel,
    output logic [4:0] grant,
    output logic       out_valid,
    output logic       busy
);

    // DATA_WIDTH only documents the mux this block sits beside; reject
    // nonsensical integrations at elaboration.
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("mux5_rr_arbiter: DATA_WIDTH must be at least 1");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 15) begin : g_bad_hold
        $error("mux5_rr_arbiter: MAX_HOLD must be in 1..15");
    end

    localparam logic [3:0] HoldLast = 4'(MAX_HOLD - 1);

    state_e     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [4:0] grant_q, grant_d;
    logic [2:0] ptr_q, ptr_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;

    logic [2:0] winner;
    logic       any_req;
    logic       owner_req;
    logic       owner_last;
    logic       beat;
    logic       release_grant;

    // ptr_q always tracks the last winner, so it doubles as the round-robin pointer
    // both in IDLE and at the moment a grant is released.
    rr_pick5 u_pick (
        .ptr_i     (ptr_q),
        .req_i     (req),
        .winner_o  (winner),
        .any_req_o (any_req)
    );

    always_comb begin
        busy       = (state_q == ST_GRANT);
        owner_req  = |(grant_q & req);
        owner_last = |(grant_q & last);
        out_valid  = busy & owner_req;
        beat       = out_valid & out_ready;
        // A withdrawn request can never coincide with a beat, since out_valid is low.
        release_grant = busy & ((beat & (owner_last | (beat_cnt_q == HoldLast))) | ~owner_req);
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d    = ST_GRANT;
                    sel_d      = winner;
                    grant_d    = 5'b00001 << winner;
                    ptr_d      = winner;
                    beat_cnt_d = 4'd0;
                end
            end
            ST_GRANT: begin
                if (release_grant) begin
                    beat_cnt_d = 4'd0;
                    if (any_req) begin
                        // Back-to-back handoff; the releasing source is scanned last.
                        sel_d   = winner;
                        grant_d = 5'b00001 << winner;
                        ptr_d   = winner;
                    end else begin
                        // sel keeps its last value while idle.
                        state_d = ST_IDLE;
                        grant_d = 5'b00000;
                    end
                end else if (beat && (beat_cnt_q < HoldLast)) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 5'b00000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= SEL_U;
            grant_q    <= 5'b00000;
            ptr_q      <= SEL_Y;
            beat_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign sel   = sel_q;
    assign grant = grant_q;

endmodule
